req_ack_responder: RTL and testbench

//  Responder end of the single-bit request/response handshake (a ##N b).
//  - Samples request pulses on a; returns one response per accepted request on b, in order.
//  - A response is presented LATENCY cycles after its request at the earliest.
//  - b is held until the consumer accepts it with b_rdy.
//  - Serves as the bench-side counterpart that drives b for the a->b sequence assertions.

---
 rtl/req_ack_responder_pkg.sv | 13 +
 rtl/req_ack_responder_if.sv | 38 +++
 rtl/req_ack_responder_delay_line.sv | 42 ++++
 rtl/req_ack_responder.sv | 95 +++++++++
 tb/tb_req_ack_responder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/req_ack_responder_pkg.sv
// Shared parameters and helpers for the request/response responder.
// Provides default LATENCY/MAX_OUT and the outstanding-count width function.
package req_ack_pkg;

    localparam int LATENCY_DEF = 1;
    localparam int MAX_OUT_DEF = 4;

    // Width needed to hold a count from 0 up to and including mx.
    function automatic int cw_f(input int mx);
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/req_ack_responder_if.sv
// Handshake bundle between the requester/consumer and the responder.
// Signals: a (request), b_rdy (response accept), b (response valid),
//   busy, outstanding[CW-1:0], overflow (sticky drop flag).
//   master: requester/consumer side; slave: responder side.
interface req_ack_responder_if
    import req_ack_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF
);

    localparam int CW = cw_f(MAX_OUT);

    logic          a;
    logic          b_rdy;
    logic          b;
    logic          busy;
    logic [CW-1:0] outstanding;
    logic          overflow;

    modport master (
        output a,
        output b_rdy,
        input  b,
        input  busy,
        input  outstanding,
        input  overflow
    );

    modport slave (
        input  a,
        input  b_rdy,
        output b,
        output busy,
        output outstanding,
        output overflow
    );

endinterface

// File: rtl/req_ack_responder_delay_line.sv
// 1-bit shift register of DEPTH async-reset stages; DEPTH=0 is a wire.
// Ports: clk, rst (async, active-high), d_i (stage 0 input), q_o (tail).
module req_delay_line #(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset are not needed when the line has no stages.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_regs
            logic [DEPTH-1:0] sr_q;
            logic [DEPTH-1:0] sr_d;

            always_comb begin
                sr_d    = sr_q;
                sr_d[0] = d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/req_ack_responder.sv
// Responder end of a single-bit request/response handshake: each accepted
// request on a yields one response on b after LATENCY cycles at the earliest.
// Ports: clk, rst (async, active-high), bus (req_ack_responder_if.slave):
//   a, b_rdy in; b, busy, outstanding, overflow out.
// The interface instance must be built with the same MAX_OUT as this block.
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    req_ack_responder_if.slave   bus
);

    localparam int CW = cw_f(MAX_OUT);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] pend_q;
    logic [CW-1:0] pend_d;
    logic [CW-1:0] out_q;
    logic [CW-1:0] out_d;
    logic          b_q;
    logic          b_d;
    logic          ovf_q;
    logic          ovf_d;

    logic cmp;
    logic full;
    logic acc;
    logic drop;
    logic tail;

    // A completion in this cycle frees a slot that a new request may take.
    assign cmp  = b_q & bus.b_rdy;
    assign full = (out_q >= MAX_CNT);
    assign acc  = bus.a & (~full | cmp);
    assign drop = bus.a & ~acc;

    req_delay_line #(
        .DEPTH (LATENCY - 1)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d_i (acc),
        .q_o (tail)
    );

    always_comb begin
        pend_d = pend_q;
        out_d  = out_q;
        ovf_d  = ovf_q;

        unique case (1'b1)
            (tail & ~cmp): pend_d = pend_q + ONE;
            (~tail & cmp): pend_d = pend_q - ONE;
            default:       pend_d = pend_q;
        endcase

        unique case (1'b1)
            (acc & ~cmp): out_d = out_q + ONE;
            (~acc & cmp): out_d = out_q - ONE;
            default:      out_d = out_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end

        // b is registered from the next pend value so it is a pure flop.
        b_d = (pend_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            out_q  <= '0;
            b_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            out_q  <= out_d;
            b_q    <= b_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.b           = b_q;
    assign bus.busy        = (out_q != '0);
    assign bus.outstanding = out_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder at LATENCY 1, 2 and 3.
// Shared clock/reset; each instance has its own handshake bundle.
module tb_req_ack_responder;

    logic clk;
    logic rst;

    int n_assert;
    int n_fail;
    int n_cmp;

    req_ack_responder_if #(.MAX_OUT(4)) if1 ();
    req_ack_responder_if #(.MAX_OUT(4)) if2 ();
    req_ack_responder_if #(.MAX_OUT(4)) if3 ();

    req_ack_responder #(.LATENCY(1), .MAX_OUT(4)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    req_ack_responder #(.LATENCY(2), .MAX_OUT(4)) u2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    req_ack_responder #(.LATENCY(3), .MAX_OUT(4)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        if1.a = 1'b0; if1.b_rdy = 1'b0;
        if2.a = 1'b0; if2.b_rdy = 1'b0;
        if3.a = 1'b0; if3.b_rdy = 1'b0;
        tick();
        tick();
        check("rst_b1", {31'd0, if1.b}, 0);
        check("rst_busy1", {31'd0, if1.busy}, 0);
        check("rst_out1", {29'd0, if1.outstanding}, 0);
        check("rst_ovf1", {31'd0, if1.overflow}, 0);
        check("rst_b2", {31'd0, if2.b}, 0);
        check("rst_b3", {31'd0, if3.b}, 0);
        rst = 1'b0;
        tick();

        // LATENCY=1 single request
        if1.b_rdy = 1'b1;
        if1.a = 1'b1;
        #1;
        check("t1_b_no_comb", {31'd0, if1.b}, 0);
        tick();
        if1.a = 1'b0;
        check("t1_b_hi", {31'd0, if1.b}, 1);
        check("t1_out1", {29'd0, if1.outstanding}, 1);
        check("t1_busy", {31'd0, if1.busy}, 1);
        tick();
        check("t1_b_lo", {31'd0, if1.b}, 0);
        check("t1_out0", {29'd0, if1.outstanding}, 0);
        if1.b_rdy = 1'b0;

        // LATENCY=3 three back-to-back requests
        if3.b_rdy = 1'b1;
        if3.a = 1'b1;
        tick();
        check("t2_out_e1", {29'd0, if3.outstanding}, 1);
        check("t2_b_e1", {31'd0, if3.b}, 0);
        tick();
        check("t2_out_e2", {29'd0, if3.outstanding}, 2);
        check("t2_b_e2", {31'd0, if3.b}, 0);
        tick();
        if3.a = 1'b0;
        check("t2_out_e3", {29'd0, if3.outstanding}, 3);
        check("t2_b_e3", {31'd0, if3.b}, 1);
        tick();
        check("t2_b_e4", {31'd0, if3.b}, 1);
        check("t2_out_e4", {29'd0, if3.outstanding}, 2);
        tick();
        check("t2_b_e5", {31'd0, if3.b}, 1);
        check("t2_out_e5", {29'd0, if3.outstanding}, 1);
        tick();
        check("t2_b_e6", {31'd0, if3.b}, 0);
        check("t2_busy_e6", {31'd0, if3.busy}, 0);
        if3.b_rdy = 1'b0;

        // saturation and overflow on LATENCY=1
        if1.b_rdy = 1'b0;
        if1.a = 1'b1;
        tick(); tick(); tick(); tick();
        check("t3_out_sat", {29'd0, if1.outstanding}, 4);
        check("t3_ovf_pre", {31'd0, if1.overflow}, 0);
        check("t3_b_held", {31'd0, if1.b}, 1);
        tick();
        check("t3_out_5", {29'd0, if1.outstanding}, 4);
        check("t3_ovf_5", {31'd0, if1.overflow}, 1);
        tick();
        check("t3_out_6", {29'd0, if1.outstanding}, 4);
        if1.a = 1'b0;
        if1.b_rdy = 1'b1;
        n_cmp = 0;
        for (int i = 0; i < 8; i++) begin
            if (if1.b && if1.b_rdy) n_cmp++;
            tick();
        end
        check("t3_ncmp", n_cmp, 4);
        check("t3_out_end", {29'd0, if1.outstanding}, 0);
        check("t3_ovf_sticky", {31'd0, if1.overflow}, 1);
        if1.b_rdy = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_ovf_clr", {31'd0, if1.overflow}, 0);

        // full with simultaneous completion accepts the request
        if1.a = 1'b1;
        tick(); tick(); tick(); tick();
        check("t4_full", {29'd0, if1.outstanding}, 4);
        if1.b_rdy = 1'b1;
        tick();
        check("t4_out_same", {29'd0, if1.outstanding}, 4);
        check("t4_ovf_none", {31'd0, if1.overflow}, 0);
        if1.a = 1'b0;
        tick();
        if1.b_rdy = 1'b0;
        check("t5_out3", {29'd0, if1.outstanding}, 3);
        check("t5_b1", {31'd0, if1.b}, 1);

        // async reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("t5_b_rst", {31'd0, if1.b}, 0);
        check("t5_busy_rst", {31'd0, if1.busy}, 0);
        check("t5_out_rst", {29'd0, if1.outstanding}, 0);
        check("t5_ovf_rst", {31'd0, if1.overflow}, 0);
        rst = 1'b0;
        if1.b_rdy = 1'b1;
        n_cmp = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if1.b) n_cmp++;
        end
        check("t5_no_b", n_cmp, 0);
        if1.b_rdy = 1'b0;

        // LATENCY=2, b_rdy toggling, 8 requests: 7 accepted, 1 dropped
        n_cmp = 0;
        for (int t = 1; t <= 24; t++) begin
            if2.a = (t <= 8);
            if2.b_rdy = (t % 2 == 1);
            #1;
            if (if2.b && if2.b_rdy) n_cmp++;
            tick();
            if (t == 2) check("t6_b_first", {31'd0, if2.b}, 1);
            if (t == 7) check("t6_ovf_7", {31'd0, if2.overflow}, 0);
            if (t == 8) begin
                check("t6_out_8", {29'd0, if2.outstanding}, 4);
                check("t6_ovf_8", {31'd0, if2.overflow}, 1);
            end
        end
        check("t6_ncmp", n_cmp, 7);
        check("t6_out_end", {29'd0, if2.outstanding}, 0);
        check("t6_b_end", {31'd0, if2.b}, 0);
        check("t6_ovf_end", {31'd0, if2.overflow}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
